// File: rtl/avr_io_pkg.sv
// avr_io_pkg: shared AVR I/O constants for the pin-change interrupt block.
//   Holds the register addresses, the group index encoding (0=B,1=C,2=D,3=E)
//   and the pin width of each PCINT group.
package avr_io_pkg;
    localparam logic [5:0] PCIFR_ADDR  = 6'h1B;
    localparam logic [7:0] PCICR_ADDR  = 8'h68;
    localparam logic [7:0] PCMSK0_ADDR = 8'h6B;
    localparam logic [7:0] PCMSK3_ADDR = 8'h73;
    localparam int PCG_W0 = 8;
    localparam int PCG_W1 = 7;
    localparam int PCG_W2 = 8;
    localparam int PCG_W3 = 4;
    typedef enum logic [1:0] {PCG_B = 2'd0, PCG_C = 2'd1, PCG_D = 2'd2, PCG_E = 2'd3} pcg_e;
endpackage

// File: rtl/pcint_ctrl_if.sv
// pcint_ctrl_if: register bus between the core and the pin-change controller.
//   IO_Addr/iore/iowe   I/O-space access (PCIFR)
//   ram_Addr/ramre/ramwe data-space access (PCICR, PCMSK0..3)
//   dbus_in             write data
//   dbus_out/out_en     read data and its drive enable, returned by the slave
interface pcint_ctrl_if;
    logic [5:0] IO_Addr;
    logic       iore;
    logic       iowe;
    logic [7:0] ram_Addr;
    logic       ramre;
    logic       ramwe;
    logic [7:0] dbus_in;
    logic [7:0] dbus_out;
    logic       out_en;
    modport master (output IO_Addr, iore, iowe, ram_Addr, ramre, ramwe, dbus_in, input dbus_out, out_en);
    modport slave (input IO_Addr, iore, iowe, ram_Addr, ramre, ramwe, dbus_in, output dbus_out, out_en);
endinterface

// File: rtl/pcint_group.sv
// pcint_group: per-port pin synchroniser, history flop and masked change detect.
//   cp2, ireset  clock, synchronous active-high reset
//   i_pin[W]     raw pin levels
//   i_msk[W]     PCMSK bits of this group
//   o_edge_hit   some masked synchronised pin differs from its history
//   o_wake       combinational raw-pin change term, only with PCINT_WAKE_EN
module pcint_group #(
    parameter int W           = 8,
    parameter int SYNC_STAGES = 2
) (
    input  logic         cp2,
    input  logic         ireset,
    input  logic [W-1:0] i_pin,
    input  logic [W-1:0] i_msk,
    output logic         o_edge_hit,
    output logic         o_wake
);
    logic [W-1:0] r_sync [SYNC_STAGES];
    logic [W-1:0] r_hist;

    always_ff @(posedge cp2) begin
        if (ireset) begin
            for (int i = 0; i < SYNC_STAGES; i++) r_sync[i] <= '0;
            r_hist <= '0;
        end else begin
            r_sync[0] <= i_pin;
            for (int i = 1; i < SYNC_STAGES; i++) r_sync[i] <= r_sync[i-1];
            r_hist <= r_sync[SYNC_STAGES-1];
        end
    end

    assign o_edge_hit = |(i_msk & (r_sync[SYNC_STAGES-1] ^ r_hist));

`ifdef PCINT_WAKE_EN
    // Raw pin against history: no clock needed, so it still fires with cp2 gated.
    assign o_wake = |(i_msk & (i_pin ^ r_hist));
`else
    assign o_wake = 1'b0;
`endif
endmodule

// File: rtl/pcint_ctrl.sv
// pcint_ctrl: pin-change interrupt controller for PCINT[27:0] (ports B/C/D/E).
//   cp2, ireset        clock, synchronous active-high reset
//   bus                pcint_ctrl_if slave: PCIFR in I/O space, PCICR/PCMSK0..3 in data space
//   pinB_i..pinE_i     raw pin levels 8/7/8/4
//   pcmsk0..3, pcie    mask and enable registers exported to the ports
//   irq                per-group request PCIFR & PCICR
//   irqack, irqackad   vector acceptance, clears the addressed flag
//   wake_req           combinational wake request when PCINT_WAKE_EN is defined, else 0
module pcint_ctrl #(
    parameter logic [5:0] PCIFR_ADDR  = avr_io_pkg::PCIFR_ADDR,
    parameter logic [7:0] PCICR_ADDR  = avr_io_pkg::PCICR_ADDR,
    parameter logic [7:0] PCMSK0_ADDR = avr_io_pkg::PCMSK0_ADDR,
    parameter logic [7:0] PCMSK3_ADDR = avr_io_pkg::PCMSK3_ADDR,
    parameter int         SYNC_STAGES = 2
) (
    input  logic         cp2,
    input  logic         ireset,
    pcint_ctrl_if.slave  bus,
    input  logic [7:0]   pinB_i,
    input  logic [6:0]   pinC_i,
    input  logic [7:0]   pinD_i,
    input  logic [3:0]   pinE_i,
    output logic [7:0]   pcmsk0,
    output logic [6:0]   pcmsk1,
    output logic [7:0]   pcmsk2,
    output logic [3:0]   pcmsk3,
    output logic [3:0]   pcie,
    output logic [3:0]   irq,
    input  logic         irqack,
    input  logic [1:0]   irqackad,
    output logic         wake_req
);
    import avr_io_pkg::*;

    logic [3:0] r_pcicr;
    logic [3:0] r_pcifr;
    logic [7:0] r_pcmsk0;
    logic [6:0] r_pcmsk1;
    logic [7:0] r_pcmsk2;
    logic [3:0] r_pcmsk3;
    logic [3:0] w_hit;
    logic [3:0] w_wake;
    logic [3:0] w_msel;
    logic [3:0] w_ack;
    logic [3:0] w_clr;
    logic       w_fr_sel;
    logic       w_cr_sel;

    pcint_group #(.W(PCG_W0), .SYNC_STAGES(SYNC_STAGES)) u_grp_b (.cp2(cp2), .ireset(ireset), .i_pin(pinB_i), .i_msk(r_pcmsk0), .o_edge_hit(w_hit[0]), .o_wake(w_wake[0]));
    pcint_group #(.W(PCG_W1), .SYNC_STAGES(SYNC_STAGES)) u_grp_c (.cp2(cp2), .ireset(ireset), .i_pin(pinC_i), .i_msk(r_pcmsk1), .o_edge_hit(w_hit[1]), .o_wake(w_wake[1]));
    pcint_group #(.W(PCG_W2), .SYNC_STAGES(SYNC_STAGES)) u_grp_d (.cp2(cp2), .ireset(ireset), .i_pin(pinD_i), .i_msk(r_pcmsk2), .o_edge_hit(w_hit[2]), .o_wake(w_wake[2]));
    pcint_group #(.W(PCG_W3), .SYNC_STAGES(SYNC_STAGES)) u_grp_e (.cp2(cp2), .ireset(ireset), .i_pin(pinE_i), .i_msk(r_pcmsk3), .o_edge_hit(w_hit[3]), .o_wake(w_wake[3]));

    assign w_fr_sel  = bus.IO_Addr == PCIFR_ADDR;
    assign w_cr_sel  = bus.ram_Addr == PCICR_ADDR;
    assign w_msel[0] = bus.ram_Addr == PCMSK0_ADDR;
    assign w_msel[1] = bus.ram_Addr == PCMSK0_ADDR + 8'd1;
    assign w_msel[2] = bus.ram_Addr == PCMSK0_ADDR + 8'd2;
    assign w_msel[3] = bus.ram_Addr == PCMSK3_ADDR;
    assign w_ack     = {irqackad == PCG_E, irqackad == PCG_D, irqackad == PCG_C, irqackad == PCG_B};
    assign w_clr     = ({4{bus.iowe & w_fr_sel}} & bus.dbus_in[3:0]) | ({4{irqack}} & w_ack);

    always_ff @(posedge cp2) begin
        if (ireset) begin
            r_pcicr  <= '0;
            r_pcifr  <= '0;
            r_pcmsk0 <= '0;
            r_pcmsk1 <= '0;
            r_pcmsk2 <= '0;
            r_pcmsk3 <= '0;
        end else begin
            // A new edge outranks any clear arriving in the same cycle.
            r_pcifr <= w_hit | (r_pcifr & ~w_clr);
            if (bus.ramwe) begin
                if (w_cr_sel) r_pcicr <= bus.dbus_in[3:0];
                if (w_msel[0]) r_pcmsk0 <= bus.dbus_in;
                if (w_msel[1]) r_pcmsk1 <= bus.dbus_in[6:0];
                if (w_msel[2]) r_pcmsk2 <= bus.dbus_in;
                if (w_msel[3]) r_pcmsk3 <= bus.dbus_in[3:0];
            end
        end
    end

    assign bus.out_en   = (bus.iore & w_fr_sel) | (bus.ramre & (w_cr_sel | (|w_msel)));
    assign bus.dbus_out = (bus.iore & w_fr_sel) ? {4'b0, r_pcifr} :
                          !bus.ramre            ? 8'h00 :
                          w_cr_sel              ? {4'b0, r_pcicr} :
                          w_msel[0]             ? r_pcmsk0 :
                          w_msel[1]             ? {1'b0, r_pcmsk1} :
                          w_msel[2]             ? r_pcmsk2 :
                          w_msel[3]             ? {4'b0, r_pcmsk3} : 8'h00;

    assign pcmsk0   = r_pcmsk0;
    assign pcmsk1   = r_pcmsk1;
    assign pcmsk2   = r_pcmsk2;
    assign pcmsk3   = r_pcmsk3;
    assign pcie     = r_pcicr;
    assign irq      = r_pcifr & r_pcicr;
    assign wake_req = |(r_pcicr & w_wake);
endmodule
